// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//
// Load-use hazard detector for the ID stage of the 5-stage MIPS pipeline
// (R-type, lw, sw, beq). It keeps a small shadow of the ID/EX register
// (valid, memRead, rt) so it can spot an instruction in ID that reads the
// destination of a load sitting in EX. It also applies the branch flush and
// counts stall and flush cycles in saturating debug counters.
//
// Ports
//   clk          in   pipeline clock, rising edge
//   reset        in   synchronous, active-high
//   idValid      in   IF/ID holds a real instruction (not a bubble)
//   idOpCode     in   [5:0] opcode of the instruction in ID
//   idRs         in   [4:0] rs field of the instruction in ID
//   idRt         in   [4:0] rt field of the instruction in ID
//   branchTaken  in   beq resolved taken this cycle (MEM stage)
//   stallSignal  out  zero the control word going into ID/EX (bubble)
//   pcWrite      out  PC update enable
//   ifidWrite    out  IF/ID write enable
//   flush        out  clear IF/ID, ID/EX and EX/MEM this cycle
//   stallCount   out  [CNT_W-1:0] load-use stall cycles, saturating
//   flushCount   out  [CNT_W-1:0] flush cycles, saturating
// ---------------------------------------------------------------------------
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             idValid,
    input  logic [5:0]       idOpCode,
    input  logic [4:0]       idRs,
    input  logic [4:0]       idRt,
    input  logic             branchTaken,
    output logic             stallSignal,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             flush,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;

    logic             r_exValid;
    logic             r_exMemRead;
    logic [4:0]       r_exRt;
    logic [CNT_W-1:0] r_stallCount;
    logic [CNT_W-1:0] r_flushCount;

    logic             w_readsRt;
    logic             w_isLoad;
    logic             w_hazard;

    // R-type, sw and beq read rt. Everything else (lw and any unknown opcode)
    // reads rs only and decodes as a load, mirroring the controller default.
    always_comb begin
        w_readsRt = (idOpCode == OP_RTYPE) || (idOpCode == OP_SW) ||
                    (idOpCode == OP_BEQ);
        w_isLoad  = !w_readsRt;
    end

    always_comb begin
        w_hazard = 1'b0;
        if (idValid && r_exValid && r_exMemRead && (r_exRt != 5'd0)) begin
            w_hazard = (r_exRt == idRs) || (w_readsRt && (r_exRt == idRt));
        end
    end

    // Branch flush squashes the ID instruction, so it overrides a stall.
    // Under reset the pipeline runs freely with no flush or stall.
    always_comb begin
        stallSignal = 1'b0;
        pcWrite     = 1'b1;
        ifidWrite   = 1'b1;
        flush       = 1'b0;
        if (!reset) begin
            if (branchTaken) begin
                flush = 1'b1;
            end else if (w_hazard) begin
                stallSignal = 1'b1;
                pcWrite     = 1'b0;
                ifidWrite   = 1'b0;
            end
        end
    end

    // ID/EX shadow. A bubble clears valid/memRead; rt is left as-is since it
    // is only consulted while memRead is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exValid   <= 1'b0;
            r_exMemRead <= 1'b0;
            r_exRt      <= 5'd0;
        end else if (flush || stallSignal) begin
            r_exValid   <= 1'b0;
            r_exMemRead <= 1'b0;
        end else begin
            r_exValid   <= idValid;
            r_exMemRead <= w_isLoad;
            r_exRt      <= idRt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else begin
            if (stallSignal && (r_stallCount != '1)) begin
                r_stallCount <= r_stallCount + CNT_W'(1);
            end
            if (flush && (r_flushCount != '1)) begin
                r_flushCount <= r_flushCount + CNT_W'(1);
            end
        end
    end

    assign stallCount = r_stallCount;
    assign flushCount = r_flushCount;

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard detector that generates the `stallSignal` consumed by `controlUnit`, plus the PC and IF/ID write enables and the branch flush. It sits beside the ID stage of the 5-stage MIPS pipeline (R-type, lw, sw, beq). It keeps its own shadow of the ID/EX stage so it can detect load-use dependencies, and it counts stall and flush events for debug.

## Interface
- `CNT_W`, default 16: width of the saturating event counters.
- `clk` input 1: pipeline clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `idValid` input 1: the IF/ID register holds a real instruction, not a bubble.
- `idOpCode` input 6: opcode of the instruction in ID.
- `idRs` input 5: rs field of the instruction in ID.
- `idRt` input 5: rt field of the instruction in ID.
- `branchTaken` input 1: a beq resolved taken this cycle (MEM stage).
- `stallSignal` output 1: forces the control outputs into the ID/EX register to zero (bubble).
- `pcWrite` output 1: PC update enable.
- `ifidWrite` output 1: IF/ID register write enable.
- `flush` output 1: clears IF/ID, ID/EX and EX/MEM this cycle.
- `stallCount` output CNT_W: number of load-use stall cycles, saturating.
- `flushCount` output CNT_W: number of flush cycles, saturating.

## Operation
- Decode classes for `idOpCode`:
  - 0 is R-type: reads rs and rt, writes a register.
  - 35 is lw: reads rs, load.
  - 43 is sw: reads rs and rt.
  - 4 is beq: reads rs and rt.
  - Any other opcode is treated as a load that reads rs only. This matches the controller's default decode, which asserts memRead and regWrite.
- Shadow registers: `exValid`, `exMemRead` and `exRt[4:0]`, all updated every cycle.
  - When `flush` or `stallSignal` is high: `exValid`=0 and `exMemRead`=0 (bubble).
  - Otherwise: `exValid`=`idValid`, `exMemRead`=1 for the load class, and `exRt`=`idRt`.
- Load-use hazard is detected when all of these hold:
  - `idValid`, `exValid` and `exMemRead` are high.
  - `exRt` is not 0.
  - `exRt`==`idRs`, or the ID instruction reads rt and `exRt`==`idRt`.
- Output priority:
  1. `branchTaken`: `flush`=1, `stallSignal`=0, `pcWrite`=1, `ifidWrite`=1. Any load-use hazard that cycle is ignored because the ID instruction is being squashed.
  2. Load-use hazard: `stallSignal`=1, `pcWrite`=0, `ifidWrite`=0, `flush`=0.
  3. Otherwise: `stallSignal`=0, `pcWrite`=1, `ifidWrite`=1, `flush`=0.
- Counters:
  - `stallCount` increments by 1 in each cycle where `stallSignal`=1.
  - `flushCount` increments by 1 in each cycle where `flush`=1.
  - Both stop at 2^CNT_W−1 and never wrap.

## Timing
- `stallSignal`, `pcWrite`, `ifidWrite` and `flush` are combinational from the shadow registers, the current ID fields and `branchTaken`. They are valid in the same cycle as the condition, with zero latency.
- A load-use stall lasts exactly 1 cycle. The bubble written to the shadow clears the hazard in the next cycle, and the held instruction then issues.
- Back-to-back loads (lw then a dependent lw) stall 1 cycle, then proceed.
- The shadow and counters update on the rising `clk` edge. The counters reflect an event one cycle after it occurs.
- Reset:
  - The shadow is cleared (`exValid`=0, `exMemRead`=0, `exRt`=0).
  - The counters are cleared to 0.
  - While `reset` is high, outputs are forced to `stallSignal`=0, `pcWrite`=1, `ifidWrite`=1, `flush`=0, regardless of `branchTaken`.
- Reset mid-stall: the stall is dropped on the first reset cycle. No hazard can be detected on the first cycle after reset, because `exValid`=0.
- `idValid`=0: no hazard is detected, and the shadow captures `exValid`=0.
- A dependency through register $0 never stalls.

## Test plan
- R-type after a load: cycle 0 has ID=lw $8 (opCode 35, rt=8); cycle 1 has ID=add (opCode 0, rs=8). Expected: in cycle 1 `stallSignal`=1, `pcWrite`=0, `ifidWrite`=0; in cycle 2 all three are back to 0/1/1; `stallCount`=1.
- Independent instructions: lw rt=8, then sw with rs=9 and rt=10. Expected: no stall. Then lw rt=8, then sw with rt=8. Expected: a 1-cycle stall, because sw reads rt.
- Load into $0: lw rt=0, then add with rs=0. Expected: no stall. Unsupported opcode 12 with rt=5, then beq with rt=5. Expected: a 1-cycle stall.
- Flush beats stall: load-use hazard and `branchTaken`=1 in the same cycle. Expected: `flush`=1, `stallSignal`=0, `pcWrite`=1; the next cycle has no stall, because the shadow holds a bubble; `flushCount`=1.
- Reset: assert `reset` during a stall cycle. Expected: that cycle shows `stallSignal`=0 and `pcWrite`=1; the counters read 0 on the next cycle; `branchTaken`=1 under reset gives `flush`=0.
- Saturation with CNT_W=2: apply 5 stall events. Expected: `stallCount` holds 3.
